// File: rtl/uart_rx_frm.sv
// uart_rx_frm -- 8N1 UART receiver, LSB first, for the serial command path.
//
// Each received byte is presented on rx_data together with a level rdy flag.
// rdy holds until the consumer pulses clr_rdy or the next start bit is confirmed.
// Two protections are built in:
//   * False-start rejection: the start bit is re-checked at its centre.
//   * Framing-error detection: a low stop bit sets frm_err.
//
// Ports:
//   clk      system clock, all logic on posedge
//   rst      synchronous, active-high reset
//   RX       asynchronous serial line, idles high
//   clr_rdy  consumer pulse that clears rdy
//   rx_data  last correctly framed byte
//   rdy      byte-valid level flag
//   frm_err  sticky: the last frame had a bad stop bit (cleared by a good frame)
//
// Parameters:
//   BAUD_CYCLES  clk cycles per bit; must be even and >= 8
//   CNT_W        baud counter width; 2**CNT_W must exceed BAUD_CYCLES

module uart_rx_frm #(
    parameter int BAUD_CYCLES = 2604,
    parameter int CNT_W       = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // A half-bit load puts the start-bit sample at the bit centre. Every
    // later sample is then one full bit further on.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;

    logic             rx_meta_r;
    logic             rx_sync_r;
    logic             rx_prev_r;

    logic [CNT_W-1:0] baud_cnt_r;
    logic [CNT_W-1:0] baud_cnt_nxt_s;
    logic [3:0]       bit_cnt_r;
    logic [3:0]       bit_cnt_nxt_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_nxt_s;

    logic [7:0]       rx_data_r;
    logic [7:0]       rx_data_nxt_s;
    logic             rdy_r;
    logic             rdy_nxt_s;
    logic             frm_err_r;
    logic             frm_err_nxt_s;

    logic             fall_edge_s;
    logic             baud_zero_s;

    // The synchronizer and edge-history flops reset to the idle level.
    // As a result, reset itself never manufactures a falling edge.
    assign fall_edge_s = rx_prev_r & ~rx_sync_r;
    assign baud_zero_s = (baud_cnt_r == CNT_ZERO);

    assign rx_data = rx_data_r;
    assign rdy     = rdy_r;
    assign frm_err = frm_err_r;

    // Two-flop synchronizer on RX, plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= RX;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: a frame advances only at bit-centre sample points.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fall_edge_s) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_zero_s) begin
                    if (rx_sync_r) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                // The sample taken while bit_cnt is 7 is the eighth data bit.
                if (baud_zero_s && (bit_cnt_r == 4'd7)) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (baud_zero_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Datapath and output next values for counters, shifter and outputs.
    always_comb begin
        baud_cnt_nxt_s = baud_cnt_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        shift_nxt_s    = shift_r;
        rx_data_nxt_s  = rx_data_r;
        frm_err_nxt_s  = frm_err_r;
        // The consumer clear applies unless a good stop bit sets rdy
        // in this same cycle.
        if (clr_rdy) begin
            rdy_nxt_s = 1'b0;
        end else begin
            rdy_nxt_s = rdy_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (fall_edge_s) begin
                    baud_cnt_nxt_s = HALF_LOAD;
                end else begin
                    baud_cnt_nxt_s = baud_cnt_r;
                end
            end
            ST_START: begin
                if (baud_zero_s) begin
                    if (rx_sync_r) begin
                        // False start: drop back quietly and leave outputs untouched.
                        baud_cnt_nxt_s = baud_cnt_r;
                    end else begin
                        rdy_nxt_s      = 1'b0;
                        baud_cnt_nxt_s = FULL_LOAD;
                        bit_cnt_nxt_s  = 4'd0;
                    end
                end else begin
                    baud_cnt_nxt_s = baud_cnt_r - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (baud_zero_s) begin
                    // LSB arrives first, so shift right and insert at the MSB.
                    shift_nxt_s    = {rx_sync_r, shift_r[7:1]};
                    bit_cnt_nxt_s  = bit_cnt_r + 4'd1;
                    baud_cnt_nxt_s = FULL_LOAD;
                end else begin
                    baud_cnt_nxt_s = baud_cnt_r - CNT_ONE;
                end
            end
            ST_STOP: begin
                if (baud_zero_s) begin
                    if (rx_sync_r) begin
                        rx_data_nxt_s = shift_r;
                        rdy_nxt_s     = 1'b1;
                        frm_err_nxt_s = 1'b0;
                    end else begin
                        frm_err_nxt_s = 1'b1;
                    end
                end else begin
                    baud_cnt_nxt_s = baud_cnt_r - CNT_ONE;
                end
            end
            default: begin
                baud_cnt_nxt_s = CNT_ZERO;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt_r <= CNT_ZERO;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 8'h00;
            rx_data_r  <= 8'h00;
            rdy_r      <= 1'b0;
            frm_err_r  <= 1'b0;
        end else begin
            baud_cnt_r <= baud_cnt_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            shift_r    <= shift_nxt_s;
            rx_data_r  <= rx_data_nxt_s;
            rdy_r      <= rdy_nxt_s;
            frm_err_r  <= frm_err_nxt_s;
        end
    end

endmodule

// File: tb/tb_uart_rx_frm.sv
// Testbench for uart_rx_frm, using a short bit time of 16 clocks.
// Serial frames are built bit by bit from the byte value.
// Expected outputs come from a frame-level model:
//   * good frame -> byte, ready, no error
//   * bad stop   -> error, not ready, data kept
//   * clear      -> not ready
//   * reset      -> all zero

module tb_uart_rx_frm;

    localparam int BC = 16;
    localparam int CW = 5;
    localparam int STOP_SAMPLE_C = 9 * BC + BC / 2 + 2;
    localparam int EXP_LAT = 3 + BC / 2 + 9 * BC;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;
    int rise_cyc = 0;
    logic rdy_q = 1'b0;

    logic [7:0] exp_data;
    logic       exp_rdy;
    logic       exp_err;

    uart_rx_frm #(.BAUD_CYCLES(BC), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err)
    );

    always #5 clk = ~clk;

    // Cycle counter for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Track rdy edges away from the active clock edge.
    always @(negedge clk) begin
        rdy_q <= rdy;
        if (rdy && !rdy_q) begin
            rise_cnt <= rise_cnt + 1;
            rise_cyc <= cyc;
        end
        if (!rdy && rdy_q) fall_cnt <= fall_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) tick();
    endtask

    // Drive one frame: start, 8 data bits LSB first, then stop_len bit
    // times of stop_val. clr_c pulses clr_rdy in that frame cycle.
    // Driving stops early after max_c cycles.
    task automatic send_frame(input logic [7:0] data, input logic stop_val,
                              input int stop_len, input int clr_c, input int max_c);
        int total;
        int b;
        logic [7:0] sh;
        total = (9 + stop_len) * BC;
        for (int c = 0; c < total && c < max_c; c++) begin
            b = c / BC;
            if (b == 0) RX = 1'b0;
            else if (b <= 8) begin
                sh = data >> (b - 1);
                RX = sh[0];
            end else RX = stop_val;
            clr_rdy = (c == clr_c);
            tick();
        end
        clr_rdy = 1'b0;
    endtask

    // Frame-level reference: the effect of one complete frame on the outputs.
    task automatic model_frame(input logic [7:0] data, input logic stop_good);
        if (stop_good) begin
            exp_data = data;
            exp_rdy  = 1'b1;
            exp_err  = 1'b0;
        end else begin
            exp_rdy  = 1'b0;
            exp_err  = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; RX = 1'b1; clr_rdy = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        exp_data = 8'h00; exp_rdy = 1'b0; exp_err = 1'b0;
        tick();
        n_cmp++;
        if ({rx_data, rdy, frm_err} !== {exp_data, exp_rdy, exp_err}) begin
            n_mis++;
            $display("FAIL reset: got data=%02h rdy=%0b err=%0b, expected %02h/%0b/%0b",
                     rx_data, rdy, frm_err, exp_data, exp_rdy, exp_err);
        end
    endtask

    task automatic test_glitch();
        int r0;
        r0 = rise_cnt;
        RX = 1'b0;
        repeat (BC / 4) tick();
        idle(2 * BC);
        n_cmp++;
        if ({rx_data, rdy, frm_err, rise_cnt} !== {exp_data, exp_rdy, exp_err, r0}) begin
            n_mis++;
            $display("FAIL glitch: got data=%02h rdy=%0b err=%0b rises=%0d, expected %02h/%0b/%0b/%0d",
                     rx_data, rdy, frm_err, rise_cnt, exp_data, exp_rdy, exp_err, r0);
        end
        send_frame(8'h73, 1'b1, 1, -1, 1000);
        model_frame(8'h73, 1'b1);
        idle(4);
        n_cmp++;
        if ({rx_data, rdy, frm_err} !== {exp_data, exp_rdy, exp_err}) begin
            n_mis++;
            $display("FAIL glitch_then_frame: got %02h/%0b/%0b, expected %02h/%0b/%0b",
                     rx_data, rdy, frm_err, exp_data, exp_rdy, exp_err);
        end
    endtask

    task automatic test_basic_latency();
        int start_c;
        int r0;
        int lat;
        r0 = rise_cnt;
        start_c = cyc;
        send_frame(8'h67, 1'b1, 1, -1, 1000);
        model_frame(8'h67, 1'b1);
        lat = rise_cyc - start_c;
        n_cmp++;
        if (rise_cnt != r0 + 1 || lat < EXP_LAT - 1 || lat > EXP_LAT + 1) begin
            n_mis++;
            $display("FAIL latency: got rises=%0d latency=%0d, expected rises=%0d latency=%0d+-1",
                     rise_cnt - r0, lat, 1, EXP_LAT);
        end
        idle(4);
        n_cmp++;
        if ({rx_data, rdy, frm_err} !== {exp_data, exp_rdy, exp_err}) begin
            n_mis++;
            $display("FAIL basic_67: got %02h/%0b/%0b, expected %02h/%0b/%0b",
                     rx_data, rdy, frm_err, exp_data, exp_rdy, exp_err);
        end
    endtask

    task automatic test_back_to_back();
        int r0;
        int f0;
        send_frame(8'h67, 1'b1, 1, -1, 1000);
        model_frame(8'h67, 1'b1);
        n_cmp++;
        if ({rx_data, rdy} !== {exp_data, exp_rdy}) begin
            n_mis++;
            $display("FAIL b2b_first: got %02h/%0b, expected %02h/%0b", rx_data, rdy, exp_data, exp_rdy);
        end
        r0 = rise_cnt;
        f0 = fall_cnt;
        send_frame(8'h73, 1'b1, 1, -1, 1000);
        model_frame(8'h73, 1'b1);
        n_cmp++;
        if (fall_cnt != f0 + 1 || rise_cnt != r0 + 1) begin
            n_mis++;
            $display("FAIL b2b_rdy_edges: got falls=%0d rises=%0d, expected 1/1",
                     fall_cnt - f0, rise_cnt - r0);
        end
        idle(4);
        n_cmp++;
        if ({rx_data, rdy, frm_err} !== {exp_data, exp_rdy, exp_err}) begin
            n_mis++;
            $display("FAIL b2b_second: got %02h/%0b/%0b, expected %02h/%0b/%0b",
                     rx_data, rdy, frm_err, exp_data, exp_rdy, exp_err);
        end
    endtask

    task automatic test_frame_error();
        send_frame(8'hA5, 1'b0, 2, -1, 1000);
        model_frame(8'hA5, 1'b0);
        idle(4);
        n_cmp++;
        if ({rx_data, rdy, frm_err} !== {exp_data, exp_rdy, exp_err}) begin
            n_mis++;
            $display("FAIL frame_error: got %02h/%0b/%0b, expected %02h/%0b/%0b",
                     rx_data, rdy, frm_err, exp_data, exp_rdy, exp_err);
        end
        send_frame(8'h5A, 1'b1, 1, -1, 1000);
        model_frame(8'h5A, 1'b1);
        idle(4);
        n_cmp++;
        if ({rx_data, rdy, frm_err} !== {exp_data, exp_rdy, exp_err}) begin
            n_mis++;
            $display("FAIL after_error: got %02h/%0b/%0b, expected %02h/%0b/%0b",
                     rx_data, rdy, frm_err, exp_data, exp_rdy, exp_err);
        end
    endtask

    task automatic test_clr_rdy();
        clr_rdy = 1'b1;
        tick();
        clr_rdy = 1'b0;
        exp_rdy = 1'b0;
        n_cmp++;
        if ({rx_data, rdy, frm_err} !== {exp_data, exp_rdy, exp_err}) begin
            n_mis++;
            $display("FAIL clr_rdy: got %02h/%0b/%0b, expected %02h/%0b/%0b",
                     rx_data, rdy, frm_err, exp_data, exp_rdy, exp_err);
        end
        clr_rdy = 1'b1;
        tick();
        clr_rdy = 1'b0;
        idle(2);
        n_cmp++;
        if ({rx_data, rdy, frm_err} !== {exp_data, exp_rdy, exp_err}) begin
            n_mis++;
            $display("FAIL clr_when_idle: got %02h/%0b/%0b, expected %02h/%0b/%0b",
                     rx_data, rdy, frm_err, exp_data, exp_rdy, exp_err);
        end
        // Clear coincides with the stop-bit sample: the set must win.
        send_frame(8'h3C, 1'b1, 1, STOP_SAMPLE_C, 1000);
        model_frame(8'h3C, 1'b1);
        idle(4);
        n_cmp++;
        if ({rx_data, rdy, frm_err} !== {exp_data, exp_rdy, exp_err}) begin
            n_mis++;
            $display("FAIL clr_vs_set: got %02h/%0b/%0b, expected %02h/%0b/%0b",
                     rx_data, rdy, frm_err, exp_data, exp_rdy, exp_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        // Cut the frame during data bit 4 (frame bit index 5).
        send_frame(8'hFF, 1'b1, 1, -1, 5 * BC + BC / 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_data = 8'h00; exp_rdy = 1'b0; exp_err = 1'b0;
        n_cmp++;
        if ({rx_data, rdy, frm_err} !== {exp_data, exp_rdy, exp_err}) begin
            n_mis++;
            $display("FAIL reset_mid_frame: got %02h/%0b/%0b, expected %02h/%0b/%0b",
                     rx_data, rdy, frm_err, exp_data, exp_rdy, exp_err);
        end
        idle(2 * BC);
        send_frame(8'h67, 1'b1, 1, -1, 1000);
        model_frame(8'h67, 1'b1);
        idle(4);
        n_cmp++;
        if ({rx_data, rdy, frm_err} !== {exp_data, exp_rdy, exp_err}) begin
            n_mis++;
            $display("FAIL after_reset_frame: got %02h/%0b/%0b, expected %02h/%0b/%0b",
                     rx_data, rdy, frm_err, exp_data, exp_rdy, exp_err);
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic good;
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            send_frame(d, good, 1, -1, 1000);
            model_frame(d, good);
            idle($urandom_range(2, 20));
            n_cmp++;
            if ({rx_data, rdy, frm_err} !== {exp_data, exp_rdy, exp_err}) begin
                n_mis++;
                $display("FAIL random[%0d] byte %02h good=%0b: got %02h/%0b/%0b, expected %02h/%0b/%0b",
                         i, d, good, rx_data, rdy, frm_err, exp_data, exp_rdy, exp_err);
            end
            if ($urandom_range(0, 1) == 1) begin
                clr_rdy = 1'b1;
                tick();
                clr_rdy = 1'b0;
                exp_rdy = 1'b0;
                n_cmp++;
                if ({rx_data, rdy, frm_err} !== {exp_data, exp_rdy, exp_err}) begin
                    n_mis++;
                    $display("FAIL random_clr[%0d]: got %02h/%0b/%0b, expected %02h/%0b/%0b",
                             i, rx_data, rdy, frm_err, exp_data, exp_rdy, exp_err);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_basic_latency();
        test_back_to_back();
        test_frame_error();
        test_clr_rdy();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
